// File: rtl/key_arbiter_if.sv
// Keypad front-end bundle: raw keys and enable in, arbitrated note and command pulses out.
interface key_arbiter_if;
  logic        en;
  logic [14:0] keypad_i;
  logic [3:0]  keycode;
  logic        note_on;
  logic        mode_key;
  logic        sound_edge;

  modport master (
    output en, keypad_i,
    input  keycode, note_on, mode_key, sound_edge
  );

  modport slave (
    input  en, keypad_i,
    output keycode, note_on, mode_key, sound_edge
  );
endinterface

// File: rtl/key_arbiter.sv
// Keypad scanner: 2-flop sync, tick-sampled debounce, last-note-priority arbitration of
// the 12 note keys and one-cycle command pulses for the mode and sound-series keys.
module key_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic          clk,
  input  logic          n_rst,
  key_arbiter_if.slave  kif
);

  localparam logic [19:0] TICK_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [14:0] sync1, sync2, samp, db;
  logic [13:0] db_d;
  logic [19:0] tick_cnt;
  logic        tick;
  logic [14:0] stable;
  logic [13:0] press;
  logic [11:0] rel;
  logic [3:0]  cur, cur_nxt;
  logic [3:0]  hi_press, lo_held;
  logic        cur_rel;
  logic        note_on_q, mode_q, sound_q;
  logic        unused_reserved;

  assign tick   = (tick_cnt == TICK_LAST);
  assign stable = ~(sync2 ^ samp);
  assign press  = db[13:0] & ~db_d;
  assign rel    = ~db[11:0] & db_d[11:0];

  // Key 14 is debounced like the others but has no consumer.
  assign unused_reserved = db[14];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1    <= '0;
      sync2    <= '0;
      samp     <= '0;
      db       <= '0;
      db_d     <= '0;
      tick_cnt <= '0;
    end else begin
      sync1 <= kif.keypad_i;
      sync2 <= sync1;
      db_d  <= db[13:0];
      if (tick) begin
        tick_cnt <= '0;
        samp     <= sync2;
        // A bit only moves when two consecutive tick samples agree.
        db       <= (db & ~stable) | (sync2 & stable);
      end else begin
        tick_cnt <= tick_cnt + 20'd1;
      end
    end
  end

  always_comb begin
    hi_press = 4'd0;
    lo_held  = 4'd0;
    cur_rel  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (press[i]) hi_press = 4'(i + 1);
      if (cur == 4'(i + 1) && rel[i]) cur_rel = 1'b1;
    end
    for (int i = 11; i >= 0; i--) begin
      if (db[i]) lo_held = 4'(i + 1);
    end
  end

  // New press beats a release of the current note in the same cycle.
  always_comb begin
    cur_nxt = cur;
    if (!kif.en)
      cur_nxt = 4'd0;
    else if (|press[11:0])
      cur_nxt = hi_press;
    else if (cur_rel)
      cur_nxt = lo_held;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur       <= 4'd0;
      note_on_q <= 1'b0;
      mode_q    <= 1'b0;
      sound_q   <= 1'b0;
    end else begin
      cur       <= cur_nxt;
      note_on_q <= (cur_nxt != 4'd0);
      mode_q    <= kif.en & press[12];
      sound_q   <= kif.en & press[13];
    end
  end

  assign kif.keycode    = cur;
  assign kif.note_on    = note_on_q;
  assign kif.mode_key   = mode_q;
  assign kif.sound_edge = sound_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter with a 4-cycle debounce tick.
module tb_key_arbiter;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  int   cyc;
  int   mode_cnt, sound_cnt, wide_pulse, note_bad;
  logic prev_mode, prev_sound;

  key_arbiter_if kif ();

  key_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release; the debounce tick fires on every 4th one.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    mode_cnt = 0; sound_cnt = 0; wide_pulse = 0; note_bad = 0;
    prev_mode = 1'b0; prev_sound = 1'b0;
  end

  always @(negedge clk) begin
    if (kif.mode_key === 1'b1) mode_cnt++;
    if (kif.sound_edge === 1'b1) sound_cnt++;
    if ((kif.mode_key === 1'b1 && prev_mode) || (kif.sound_edge === 1'b1 && prev_sound))
      wide_pulse++;
    if (kif.note_on !== (kif.keycode != 4'd0)) note_bad++;
    prev_mode  = (kif.mode_key === 1'b1);
    prev_sound = (kif.sound_edge === 1'b1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_note(output int first);
    first = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (kif.keycode != 4'd0) begin
        first = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic [14:0] kp;
    logic        en;
    int          wait_n;
    int          kc;
    int          mc;
    int          sc;
  } vec_t;

  vec_t tbl [25];

  initial begin
    int first;
    int c;
    int m0;

    tbl[0]  = '{15'h0000, 1'b1, 16, 0,  0, 0};
    tbl[1]  = '{15'h0008, 1'b1, 16, 4,  0, 0};
    tbl[2]  = '{15'h0088, 1'b1, 16, 8,  0, 0};
    tbl[3]  = '{15'h0008, 1'b1, 16, 4,  0, 0};
    tbl[4]  = '{15'h0000, 1'b1, 16, 0,  0, 0};
    tbl[5]  = '{15'h0800, 1'b1, 16, 12, 0, 0};
    tbl[6]  = '{15'h0801, 1'b1, 16, 1,  0, 0};
    tbl[7]  = '{15'h0800, 1'b1, 16, 12, 0, 0};
    tbl[8]  = '{15'h0000, 1'b1, 16, 0,  0, 0};
    tbl[9]  = '{15'h0004, 1'b1, 16, 3,  0, 0};
    tbl[10] = '{15'h0024, 1'b1, 16, 6,  0, 0};
    tbl[11] = '{15'h0020, 1'b1, 16, 6,  0, 0};
    tbl[12] = '{15'h0000, 1'b1, 16, 0,  0, 0};
    tbl[13] = '{15'h4000, 1'b1, 16, 0,  0, 0};
    tbl[14] = '{15'h1000, 1'b1, 16, 0,  1, 0};
    tbl[15] = '{15'h0000, 1'b1, 16, 0,  1, 0};
    tbl[16] = '{15'h0020, 1'b1, 16, 6,  1, 0};
    tbl[17] = '{15'h0020, 1'b0, 16, 0,  1, 0};
    tbl[18] = '{15'h1020, 1'b0, 16, 0,  1, 0};
    tbl[19] = '{15'h1020, 1'b1, 16, 0,  1, 0};
    tbl[20] = '{15'h1000, 1'b1, 16, 0,  1, 0};
    tbl[21] = '{15'h1020, 1'b1, 16, 6,  1, 0};
    tbl[22] = '{15'h0000, 1'b1, 16, 0,  1, 0};
    tbl[23] = '{15'h2000, 1'b1, 16, 0,  1, 1};
    tbl[24] = '{15'h0000, 1'b1, 16, 0,  1, 1};

    checks = 0;
    errors = 0;

    // Reset with key 0 held
    n_rst        = 1'b0;
    kif.en       = 1'b1;
    kif.keypad_i = 15'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_keycode", int'(kif.keycode), 0);
    chk("rst_note_on", int'(kif.note_on), 0);
    chk("rst_mode_key", int'(kif.mode_key), 0);
    chk("rst_sound_edge", int'(kif.sound_edge), 0);
    n_rst = 1'b1;
    wait_note(first);
    chk("t1_latency_cycle", first, 9);
    chk("t1_keycode", int'(kif.keycode), 1);
    chk("t1_note_on", int'(kif.note_on), 1);

    step(1);
    for (int i = 0; i < 25; i++) begin
      kif.keypad_i = tbl[i].kp;
      kif.en       = tbl[i].en;
      step(tbl[i].wait_n);
      chk($sformatf("vec%0d_keycode", i), int'(kif.keycode), tbl[i].kc);
      chk($sformatf("vec%0d_note_on", i), int'(kif.note_on), (tbl[i].kc != 0) ? 1 : 0);
      chk($sformatf("vec%0d_mode_cnt", i), mode_cnt, tbl[i].mc);
      chk($sformatf("vec%0d_sound_cnt", i), sound_cnt, tbl[i].sc);
    end

    // Mode key bounce aligned so both in-bounce ticks sample the low phase
    do step(1); while ((cyc % 4) != 3);
    c  = cyc;
    m0 = mode_cnt;
    kif.keypad_i[12] = 1'b1; step(2);
    kif.keypad_i[12] = 1'b0; step(2);
    kif.keypad_i[12] = 1'b1; step(2);
    kif.keypad_i[12] = 1'b0; step(2);
    kif.keypad_i[12] = 1'b1;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (kif.mode_key) begin
        first = cyc;
        break;
      end
    end
    chk("bounce_pulse_cycle", first - c, 18);
    step(20);
    chk("bounce_hold20_cnt", mode_cnt - m0, 1);
    step(100);
    chk("bounce_hold100_cnt", mode_cnt - m0, 1);
    kif.keypad_i = 15'h0000;
    step(16);

    // Notes 2 and 9 with the sound-series key in the same cycle
    kif.keypad_i = 15'h2204;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kif.keycode != 4'd0) begin
        first = i;
        break;
      end
    end
    chk("simul_found", (first >= 0) ? 1 : 0, 1);
    chk("simul_keycode", int'(kif.keycode), 10);
    chk("simul_sound_same_cycle", int'(kif.sound_edge), 1);
    step(20);
    chk("simul_sound_cnt", sound_cnt, 2);
    chk("simul_mode_cnt", mode_cnt, 2);
    kif.keypad_i = 15'h0000;
    step(16);
    chk("simul_release_keycode", int'(kif.keycode), 0);

    // Asynchronous reset with key 4 held
    kif.keypad_i = 15'h0010;
    step(16);
    chk("pre_rst_keycode", int'(kif.keycode), 5);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_keycode", int'(kif.keycode), 0);
    chk("async_rst_note_on", int'(kif.note_on), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    wait_note(first);
    chk("post_rst_latency_cycle", first, 9);
    chk("post_rst_keycode", int'(kif.keycode), 5);

    step(2);
    chk("pulse_width_violations", wide_pulse, 0);
    chk("note_on_consistency_violations", note_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_arbiter.md
Name: key_arbiter

Overview:
- Front-end controller for `synth_top`. It scans the 15-bit raw keypad, synchronizes and debounces every key, and arbitrates the 12 note keys onto the single shared oscillator/divider path.
- Outputs: one `keycode`, plus single-cycle command pulses (`mode_key`, `sound_edge`) for `mode_fsm` and `sound_series_fsm`.
- Sits between the raw `pb` inputs and `frequency_divider` / `mode_fsm` / `sound_series_fsm`. It fills the currently empty keypad-encoder slot.

Parameters:
- DEBOUNCE_CYCLES, 120000, clock cycles between debounce sample ticks (10 ms at 12 MHz). Legal range 2..2^20-1.

Ports:
- clk  input  1  system clock (12 MHz).
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  synth enable. 0 forces silence and suppresses pulses.
- keypad_i  input  15  raw, asynchronous, active-high keys:
  - [11:0] note keys C..B.
  - [12] mode key.
  - [13] sound-series key.
  - [14] reserved (synchronized/debounced, otherwise ignored).
- keycode  output  4  selected note: 1..12 = note key index+1; 0 = no note.
- note_on  output  1  high while keycode != 0.
- mode_key  output  1  one-cycle pulse on debounced press of key 12.
- sound_edge  output  1  one-cycle pulse on debounced press of key 13.

Behaviour:
- Reset: async, active-low. While n_rst=0:
  - All flops clear.
  - keycode=0, note_on=0, mode_key=0, sound_edge=0.
  - Sync, sample and debounced vectors = 0; tick counter = 0.
  - Reset mid-operation discards held notes and pending pulses. Keys still held after reset release are treated as new presses once debounced.
- Synchronizer: 2-flop per bit. sync = keypad_i delayed 2 cycles.
- Tick counter:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick=1 in the cycle count==DEBOUNCE_CYCLES-1.
  - Runs regardless of en.
- Debounce, on tick:
  - samp <= sync.
  - For each bit where sync==samp, db <= sync.
  - A level must be seen on two consecutive ticks to propagate. A bounce shorter than one tick period never reaches db.
- Edge detect: db_d <= db every cycle. press = db & ~db_d; rel = ~db & db_d.
- Arbitration: last-note priority, evaluated every cycle, result registered, so outputs change the cycle after db changes.
  - If any note bit in press is set: cur <= highest-index pressed note.
  - Else if the current note is in rel: cur <= lowest-index note still set in db[11:0], or none if db[11:0]==0.
  - Else cur holds.
  - Simultaneous press and release of the current note in the same cycle: the press wins.
  - keycode = cur index+1, or 0 when none.
- Command pulses:
  - mode_key <= en & press[12]; sound_edge <= en & press[13].
  - Pulse is exactly one cycle, registered, in the same cycle keycode would update.
  - Holding a key produces no further pulses.
  - Keys 12 and 13 may pulse in the same cycle.
- Enable:
  - When en=0: cur forced to none (keycode=0, note_on=0) and pulses are 0. Debounce and db tracking continue.
  - On en 0→1: cur stays none until the next press or release event. Held notes are not re-triggered until re-pressed.
- Latency, raw press (stable) to keycode/pulse: ≤ 2 + 2·DEBOUNCE_CYCLES + 2 cycles.
- note_on is registered together with keycode; it must equal (keycode!=0) in every cycle.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset with keypad_i=15'h0001 held → all outputs 0 during reset. After release, within 12 cycles: keycode=1, note_on=1.
2. Press key 3 (keycode 4), then key 7 → keycode becomes 8. Release key 7 → keycode returns to 4. Release key 3 → keycode=0, note_on=0.
3. Toggle keypad_i[12] 1,0,1,0 every 2 cycles, then hold high for 20 cycles → exactly one mode_key pulse of width 1, no pulse during the bounce. Hold 100 cycles → still one pulse.
4. Press keys 2 and 9 in the same cycle → keycode=10. Assert press of key 13 simultaneously → sound_edge pulses once in the same cycle keycode updates.
5. en=0 while key 5 is held → keycode=0. Press key 12 → no mode_key. Set en=1 → keycode stays 0 until key 5 is released and re-pressed, then keycode=6.
6. Assert n_rst=0 with key 4 held and keycode=5 → keycode=0 immediately (asynchronous). Deassert → keycode=5 after the debounce latency.
